// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON permutation sequencer.
package ascon_pkg;

   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } ascon_state_t;

   typedef enum logic [1:0] {
      RC_HOLD = 2'b00,
      RC_LOAD = 2'b01,
      RC_ADV  = 2'b10
   } rcmode_t;

   typedef enum logic [1:0] {
      SEL_P12     = 2'b00,
      SEL_P8      = 2'b01,
      SEL_P6      = 2'b10,
      SEL_P12_ALT = 2'b11
   } rounds_sel_t;

   localparam int ROUNDS_P12 = 12;
   localparam int ROUNDS_P8  = 8;
   localparam int ROUNDS_P6  = 6;

   localparam logic [3:0] START_P12 = 4'd0;
   localparam logic [3:0] START_P8  = 4'd4;
   localparam logic [3:0] START_P6  = 4'd6;

endpackage

// File: rtl/ascon_round_sched.sv
// Maps a round-count selection to the first round-constant index and the
// datapath cycle count minus one for the configured unroll factor.
module ascon_round_sched
   import ascon_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic [1:0] rounds,
   output logic [3:0] start,
   output logic [3:0] last_cnt
);

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("ascon_round_sched: UNROLL must be 1 or 2");
      end
   endgenerate

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      start    = START_P12;
      last_cnt = 4'(ROUNDS_P12 / UNROLL - 1);
      case (rounds_sel_t'(rounds))
         SEL_P8: begin
            start    = START_P8;
            last_cnt = 4'(ROUNDS_P8 / UNROLL - 1);
         end
         SEL_P6: begin
            start    = START_P6;
            last_cnt = 4'(ROUNDS_P6 / UNROLL - 1);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Sequencer for the unrolled ASCON round datapath: loads a state, recirculates
// it for N/UNROLL cycles and holds the permuted result on a valid/ready channel.
module ascon_perm_ctrl
   import ascon_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_rounds,
   input  logic [63:0] in_x0,
   input  logic [63:0] in_x1,
   input  logic [63:0] in_x2,
   input  logic [63:0] in_x3,
   input  logic [63:0] in_x4,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_x0,
   output logic [63:0] out_x1,
   output logic [63:0] out_x2,
   output logic [63:0] out_x3,
   output logic [63:0] out_x4,
   output logic [63:0] dp_xi0,
   output logic [63:0] dp_xi1,
   output logic [63:0] dp_xi2,
   output logic [63:0] dp_xi3,
   output logic [63:0] dp_xi4,
   input  logic [63:0] dp_xo0,
   input  logic [63:0] dp_xo1,
   input  logic [63:0] dp_xo2,
   input  logic [63:0] dp_xo3,
   input  logic [63:0] dp_xo4,
   output logic [1:0]  dp_rcmode,
   output logic [3:0]  dp_constti,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]   state;
   logic [3:0]   cnt;
   logic [1:0]   rounds_q;
   logic [1:0]   sched_sel;
   logic [3:0]   start_idx;
   logic [3:0]   last_cnt;
   ascon_state_t in_st;
   ascon_state_t xo_st;
   ascon_state_t xi_st;
   ascon_state_t out_q;
   rcmode_t      rcmode;

   assign in_st = {in_x0, in_x1, in_x2, in_x3, in_x4};
   assign xo_st = {dp_xo0, dp_xo1, dp_xo2, dp_xo3, dp_xo4};

   // Live selection while idle so the constant index is ready at the accept edge.
   assign sched_sel = (state == ST_IDLE) ? in_rounds : rounds_q;

   ascon_round_sched #(.UNROLL(UNROLL)) u_sched (
      .rounds   (sched_sel),
      .start    (start_idx),
      .last_cnt (last_cnt)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         rounds_q <= 2'd0;
         out_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               state    <= ST_RUN;
               cnt      <= last_cnt;
               rounds_q <= in_rounds;
            end
            ST_RUN: if (cnt == 4'd0) begin
               out_q <= xo_st;
               state <= ST_DONE;
            end else begin
               cnt <= cnt - 4'd1;
            end
            ST_DONE: if (out_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Reset overrides the combinational datapath controls as well.
   always_comb begin
      rcmode = RC_HOLD;
      xi_st  = '0;
      if (nRST) begin
         case (state)
            ST_IDLE: begin
               rcmode = RC_LOAD;
               xi_st  = in_st;
            end
            ST_RUN: begin
               rcmode = RC_ADV;
               xi_st  = xo_st;
            end
            ST_DONE: xi_st = xo_st;
            default: ;
         endcase
      end
   end

   assign in_ready   = (state == ST_IDLE);
   assign out_valid  = (state == ST_DONE);
   assign busy       = (state == ST_RUN) || (state == ST_DONE);
   assign dp_rcmode  = rcmode;
   assign dp_constti = nRST ? start_idx : 4'd0;

   assign {dp_xi0, dp_xi1, dp_xi2, dp_xi3, dp_xi4}      = xi_st;
   assign {out_x0, out_x1, out_x2, out_x3, out_x4}      = out_q;

endmodule
